// File: rtl/timer_count.sv
// BCD preset/count-down/count-up timer with IDLE/RUN/PAUSE/DONE control.
// The count advances one BCD step each TICKDIV clock cycles spent in RUN.
module timer_count #(
    parameter int NUMCELLS = 4,
    parameter int TICKDIV  = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*NUMCELLS-1:0] preset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    output logic [4*NUMCELLS-1:0] count,
    output logic                  running,
    output logic                  done
);

    // state    | meaning
    // ST_IDLE  | count loaded or reset, waiting for start
    // ST_RUN   | prescaler running, count steps on each tick
    // ST_PAUSE | count and prescaler frozen, start resumes
    // ST_DONE  | terminal value reached, only load or reset leave

    localparam int CW = 4 * NUMCELLS;
    localparam int PW = $clog2(TICKDIV);
    localparam logic [PW-1:0] PMAX = PW'(TICKDIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    logic [CW-1:0]       preset_clean;
    logic [CW-1:0]       count_up;
    logic [CW-1:0]       count_dn;
    logic [CW-1:0]       count_step;
    logic [CW-1:0]       term_val;
    logic [NUMCELLS-1:0] carry;
    logic [NUMCELLS-1:0] borrow;
    logic                at_term;
    logic                step_term;
    logic                tick;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Per-digit sanitising and ripple carry/borrow; overflow out of the top digit wraps.
    for (genvar i = 0; i < NUMCELLS; i++) begin : g_digit
        logic [3:0] pd;
        logic [3:0] cd;

        assign pd = preset[4*i +: 4];
        assign cd = count[4*i +: 4];

        assign preset_clean[4*i +: 4] = (pd > 4'd9) ? 4'd0 : pd;
        assign count_up[4*i +: 4]     = !carry[i]  ? cd : ((cd >= 4'd9) ? 4'd0 : cd + 4'd1);
        assign count_dn[4*i +: 4]     = !borrow[i] ? cd : ((cd == 4'd0) ? 4'd9 : cd - 4'd1);
        assign term_val[4*i +: 4]     = dir ? 4'd9 : 4'd0;

        if (i < NUMCELLS - 1) begin : g_chain
            assign carry[i+1]  = carry[i]  && (cd >= 4'd9);
            assign borrow[i+1] = borrow[i] && (cd == 4'd0);
        end
    end

    assign count_step = dir ? count_up : count_dn;
    assign at_term    = (count == term_val);
    assign step_term  = (count_step == term_val);
    assign tick       = (state == ST_RUN) && (presc == PMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= ST_IDLE;
                count   <= preset_clean;
                presc   <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_PAUSE: begin
                        if (start && !stop) begin
                            if (at_term) begin
                                state   <= ST_DONE;
                                presc   <= '0;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state   <= ST_RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            count <= count_step;
                            presc <= '0;
                            if (step_term) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_count.sv
// Bench for timer_count (NUMCELLS=2, TICKDIV=4): vector table, directed corner
// sequences and random stimulus against an integer-valued reference model.
module tb_timer_count;

    localparam int NC = 2;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] preset = 8'h00;
    logic [7:0] count;
    logic       running;
    logic       done;

    int errors = 0;
    int checks = 0;

    timer_count #(.NUMCELLS(NC), .TICKDIV(TD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .preset(preset),
        .start(start),
        .stop(stop),
        .dir(dir),
        .count(count),
        .running(running),
        .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as a plain integer 0..99.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    mstate_t m_st  = M_IDLE;
    int      m_val = 0;
    int      m_pre = 0;
    bit      m_done = 1'b0;
    logic    cur_dir = 1'b0;

    function automatic int san(input logic [7:0] p);
        int hi;
        int lo;
        hi = int'(p[7:4]);
        lo = int'(p[3:0]);
        if (hi > 9) hi = 0;
        if (lo > 9) lo = 0;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int term(input logic d);
        return d ? 99 : 0;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_val = 0; m_pre = 0; m_done = 1'b0;
    endtask

    task automatic model_edge(input logic l, input logic [7:0] p, input logic s,
                              input logic sp, input logic d);
        m_done = 1'b0;
        if (l) begin
            m_val = san(p); m_pre = 0; m_st = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE, M_PAUSE: begin
                    if (s && !sp) begin
                        if (m_val == term(d)) begin
                            m_st = M_DONE; m_done = 1'b1; m_pre = 0;
                        end else begin
                            m_st = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (sp) begin
                        m_st = M_PAUSE;
                    end else if (m_pre == TD - 1) begin
                        m_pre = 0;
                        m_val = d ? (m_val + 1) % 100 : (m_val + 99) % 100;
                        if (m_val == term(d)) begin
                            m_st = M_DONE; m_done = 1'b1;
                        end
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic l, input logic [7:0] p, input logic s,
                        input logic sp, input logic d, input string tag);
        load = l; preset = p; start = s; stop = sp; dir = d;
        cur_dir = d;
        @(posedge clk);
        model_edge(l, p, s, sp, d);
        @(negedge clk);
        chk({tag, " count"}, 32'(count), 32'(to_bcd(m_val)));
        chk({tag, " running"}, 32'(running), 32'(m_st == M_RUN));
        chk({tag, " done"}, 32'(done), 32'(m_done));
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, cur_dir, tag);
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] pre;
        logic       st;
        logic       sp;
        logic       d;
        logic [7:0] exp_count;
        logic       exp_run;
        logic       exp_done;
    } vec_t;

    vec_t vt[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int pulses;

        vt[0]  = '{1'b1, 8'hA7, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h45, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h45, 1'b0, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0};
        vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0};
        vt[16] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0, 1'b0};

        // Power-on reset
        #3;
        chk("reset count", 32'(count), 32'h00);
        chk("reset running", 32'(running), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Vector table
        for (int i = 0; i < 17; i++) begin
            step(vt[i].ld, vt[i].pre, vt[i].st, vt[i].sp, vt[i].d, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl count", i), 32'(count), 32'(vt[i].exp_count));
            chk($sformatf("vec%0d tbl running", i), 32'(running), 32'(vt[i].exp_run));
            chk($sformatf("vec%0d tbl done", i), 32'(done), 32'(vt[i].exp_done));
        end

        // Asynchronous reset mid-RUN, then start at 00 going down
        step(1'b1, 8'h37, 1'b0, 1'b0, 1'b0, "arst load");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "arst start");
        idle(2, "arst run");
        #2 rst_n = 1'b0;
        #1;
        chk("arst count", 32'(count), 32'h00);
        chk("arst running", 32'(running), 32'h0);
        chk("arst done", 32'(done), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "arst restart");
        chk("arst done pulse", 32'(done), 32'h1);
        idle(1, "arst after");
        chk("arst done cleared", 32'(done), 32'h0);

        // Countdown 12 -> 00
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, "down load");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "down start");
        first_done = -1;
        pulses = 0;
        for (int n = 1; n <= 60; n++) begin
            idle(1, "down run");
            if (n == 4)  chk("down first tick", 32'(count), 32'h11);
            if (n == 8)  chk("down second tick", 32'(count), 32'h10);
            if (n == 12) chk("down borrow", 32'(count), 32'h09);
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = n;
            end
        end
        chk("down done cycle", 32'(first_done), 32'd48);
        chk("down done pulses", 32'(pulses), 32'd1);
        chk("down final count", 32'(count), 32'h00);
        chk("down final running", 32'(running), 32'h0);

        // Count up with carry, then up to 99
        step(1'b1, 8'h19, 1'b0, 1'b0, 1'b1, "up load");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "up start");
        idle(4, "up run");
        chk("up carry", 32'(count), 32'h20);
        step(1'b1, 8'h98, 1'b0, 1'b0, 1'b1, "up load98");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "up start98");
        idle(4, "up run98");
        chk("up 99 count", 32'(count), 32'h99);
        chk("up 99 done", 32'(done), 32'h1);
        chk("up 99 running", 32'(running), 32'h0);

        // Pause keeps count and prescaler
        step(1'b1, 8'h50, 1'b0, 1'b0, 1'b0, "pause load");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pause start");
        idle(2, "pause run");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "pause stop");
        idle(10, "pause hold");
        chk("pause held count", 32'(count), 32'h50);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pause resume");
        idle(1, "pause remain");
        chk("pause before tick", 32'(count), 32'h50);
        idle(1, "pause remain");
        chk("pause tick", 32'(count), 32'h49);

        // Direction flip between ticks, then start ignored in DONE
        step(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, "flip load");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "flip start");
        idle(4, "flip down");
        chk("flip down tick", 32'(count), 32'h05);
        idle(2, "flip down");
        cur_dir = 1'b1;
        idle(2, "flip up");
        chk("flip up tick", 32'(count), 32'h06);
        step(1'b1, 8'h98, 1'b0, 1'b0, 1'b1, "dn load");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "dn start");
        idle(4, "dn run");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "dn restart");
        chk("dn start ignored running", 32'(running), 32'h0);
        chk("dn start ignored done", 32'(done), 32'h0);
        chk("dn start ignored count", 32'(count), 32'h99);

        // Random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            logic l, s, sp;
            logic [7:0] p;
            if ($urandom_range(0, 29) == 0) cur_dir = ~cur_dir;
            l  = ($urandom_range(0, 39) == 0);
            p  = 8'($urandom_range(0, 255));
            s  = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 19) == 0);
            step(l, p, s, sp, cur_dir, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
